// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX pipeline hazard controller.
// Build option: define DLX_FORWARDING_EN to make forwarding the default build.
// Holds the shadow-stage layouts and the register-match helper.
package dlx_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_HOLD = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

`ifdef DLX_FORWARDING_EN
    localparam bit FWD_EN_DEFAULT = 1'b1;
`else
    localparam bit FWD_EN_DEFAULT = 1'b0;
`endif

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs2_used;
    } shadow_ex_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       load;
    } shadow_mem_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
    } shadow_wb_t;

    // A stage is a producer for src only when valid and writing a real register.
    function automatic logic reg_hit(input logic vld, input logic [4:0] rd, input logic [4:0] src);
        return vld && (rd != REG_ZERO) && (rd == src);
    endfunction

endpackage

// File: rtl/dlx_fwd_unit.sv
// Forwarding select for one EX operand against the MEM and WB shadows.
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller decides whether the select is used.
module dlx_fwd_unit
    import dlx_pkg::*;
#(
    parameter int FWD_SEL_W = 2
) (
    input  logic                 src_vld,
    input  logic [4:0]           src,
    input  logic                 mem_vld,
    input  logic [4:0]           mem_rd,
    input  logic                 mem_load,
    input  logic                 wb_vld,
    input  logic [4:0]           wb_rd,
    output logic [FWD_SEL_W-1:0] sel
);

    // Youngest producer wins; a load in MEM only holds its address, never its data.
    always_comb begin
        sel = FWD_SEL_W'(FWD_RF);
        if (src_vld) begin
            if (reg_hit(mem_vld && !mem_load, mem_rd, src)) begin
                sel = FWD_SEL_W'(FWD_EXMEM);
            end else if (reg_hit(wb_vld, wb_rd, src)) begin
                sel = FWD_SEL_W'(FWD_MEMWB);
            end
        end
    end

endmodule

// File: rtl/dlx_hazard_ctrl.sv
// DLX 5-stage hazard controller: stall/bubble/flush sequencing and EX forwarding selects.
// Latency: all command outputs combinational in the cycle; shadows/FSM/counter update on clk.
// Backpressure: holds PC and IF/ID while a hazard waits; branch flush overrides any stall.
// Build option DLX_FORWARDING_EN sets the default of FWD_EN (forwarding + load-use-only stalls).
module dlx_hazard_ctrl
    import dlx_pkg::*;
#(
    parameter int FWD_SEL_W = 2,
    parameter int PERF_W    = 32,
    parameter bit FWD_EN    = FWD_EN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic [4:0]           id_rd,
    input  logic                 id_rs2_used,
    input  logic                 id_load,
    input  logic                 id_jump,
    input  logic                 ex_branch_taken,
    output logic                 pc_stall,
    output logic                 ifid_hold,
    output logic                 idex_bubble,
    output logic                 ifid_flush,
    output logic [FWD_SEL_W-1:0] fwd_a,
    output logic [FWD_SEL_W-1:0] fwd_b,
    output logic [PERF_W-1:0]    stall_cycles
);

    shadow_ex_t  ex_q,  ex_d;
    shadow_mem_t mem_q, mem_d;
    shadow_wb_t  wb_q,  wb_d;
    hz_state_e   state_q, state_d;
    logic [1:0]  hold_cnt_q, hold_cnt_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    logic       hit_ex, hit_mem, hit_wb;
    logic       hazard;
    logic [1:0] wait_m1;
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [FWD_SEL_W-1:0] fwd_a_raw, fwd_b_raw;

    // Does the ID instruction read a register still owned by an in-flight writer?
    always_comb begin
        hit_ex  = id_valid && (reg_hit(ex_q.vld, ex_q.rd, id_rs1) ||
                               (id_rs2_used && reg_hit(ex_q.vld, ex_q.rd, id_rs2)));
        hit_mem = id_valid && (reg_hit(mem_q.vld, mem_q.rd, id_rs1) ||
                               (id_rs2_used && reg_hit(mem_q.vld, mem_q.rd, id_rs2)));
        hit_wb  = id_valid && (reg_hit(wb_q.vld, wb_q.rd, id_rs1) ||
                               (id_rs2_used && reg_hit(wb_q.vld, wb_q.rd, id_rs2)));
    end

    // Stall decision and total wait minus one; without bypass the youngest writer sets the wait.
    always_comb begin
        hazard  = 1'b0;
        wait_m1 = 2'd0;
        if (FWD_EN) begin
            hazard  = hit_ex && ex_q.load;
            wait_m1 = 2'd0;
        end else if (hit_ex) begin
            hazard  = 1'b1;
            wait_m1 = 2'd2;
        end else if (hit_mem) begin
            hazard  = 1'b1;
            wait_m1 = 2'd1;
        end else if (hit_wb) begin
            hazard  = 1'b1;
            wait_m1 = 2'd0;
        end
    end

    // RUN/HOLD sequencing; a taken branch kills the stalled instruction and wins over everything.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stall      = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        if (ex_branch_taken) begin
            flush      = 1'b1;
            bubble     = 1'b1;
            state_d    = HZ_RUN;
            hold_cnt_d = 2'd0;
        end else if (state_q == HZ_HOLD) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (hold_cnt_q == 2'd0) begin
                state_d = HZ_RUN;
            end else begin
                hold_cnt_d = hold_cnt_q - 2'd1;
            end
        end else if (hazard) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (wait_m1 != 2'd0) begin
                state_d    = HZ_HOLD;
                hold_cnt_d = wait_m1 - 2'd1;
            end
        end else if (id_valid && id_jump) begin
            flush = 1'b1;
        end
    end

    // Shadow advance; a bubble enters EX as an invalid entry that matches nothing.
    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.vld      = id_valid;
            ex_d.rd       = id_rd;
            ex_d.load     = id_load;
            ex_d.rs1      = id_rs1;
            ex_d.rs2      = id_rs2;
            ex_d.rs2_used = id_rs2_used;
        end
        mem_d.vld  = ex_q.vld;
        mem_d.rd   = ex_q.rd;
        mem_d.load = ex_q.load;
        wb_d.vld   = mem_q.vld;
        wb_d.rd    = mem_q.rd;
    end

    // Saturating count of cycles in which the PC is held.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    // State registers; reset clears validity so no output can fire from stale shadows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q           <= '0;
            mem_q          <= '0;
            wb_q           <= '0;
            state_q        <= HZ_RUN;
            hold_cnt_q     <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            ex_q           <= ex_d;
            mem_q          <= mem_d;
            wb_q           <= wb_d;
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    dlx_fwd_unit #(.FWD_SEL_W(FWD_SEL_W)) u_fwd_a (
        .src_vld  (ex_q.vld),
        .src      (ex_q.rs1),
        .mem_vld  (mem_q.vld),
        .mem_rd   (mem_q.rd),
        .mem_load (mem_q.load),
        .wb_vld   (wb_q.vld),
        .wb_rd    (wb_q.rd),
        .sel      (fwd_a_raw)
    );

    dlx_fwd_unit #(.FWD_SEL_W(FWD_SEL_W)) u_fwd_b (
        .src_vld  (ex_q.vld && ex_q.rs2_used),
        .src      (ex_q.rs2),
        .mem_vld  (mem_q.vld),
        .mem_rd   (mem_q.rd),
        .mem_load (mem_q.load),
        .wb_vld   (wb_q.vld),
        .wb_rd    (wb_q.rd),
        .sel      (fwd_b_raw)
    );

    assign pc_stall     = stall;
    assign ifid_hold    = stall;
    assign idex_bubble  = bubble;
    assign ifid_flush   = flush;
    assign fwd_a        = FWD_EN ? fwd_a_raw : '0;
    assign fwd_b        = FWD_EN ? fwd_b_raw : '0;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// Directed bench: one forwarding instance and one non-forwarding instance with a 3-bit counter.
// Inputs change 1 time unit after the rising edge; outputs are compared 1 unit later.
// Control outputs are packed as {pc_stall, ifid_hold, idex_bubble, ifid_flush, fwd_a, fwd_b}.
module tb_dlx_hazard_ctrl;

    typedef struct packed {
        logic       vld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       used;
        logic       load;
        logic       jump;
        logic       br;
    } id_t;

    logic clk;
    logic reset_n;
    id_t  in_f;
    id_t  in_n;

    logic        pc_stall_f, ifid_hold_f, idex_bubble_f, ifid_flush_f;
    logic [1:0]  fwd_a_f, fwd_b_f;
    logic [31:0] stall_cycles_f;
    logic        pc_stall_n, ifid_hold_n, idex_bubble_n, ifid_flush_n;
    logic [1:0]  fwd_a_n, fwd_b_n;
    logic [2:0]  stall_cycles_n;
    logic [7:0]  ctl_f, ctl_n;

    int total;
    int bad;

    assign ctl_f = {pc_stall_f, ifid_hold_f, idex_bubble_f, ifid_flush_f, fwd_a_f, fwd_b_f};
    assign ctl_n = {pc_stall_n, ifid_hold_n, idex_bubble_n, ifid_flush_n, fwd_a_n, fwd_b_n};

    dlx_hazard_ctrl #(.FWD_SEL_W(2), .PERF_W(32), .FWD_EN(1'b1)) u_f (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_valid        (in_f.vld),
        .id_rs1          (in_f.rs1),
        .id_rs2          (in_f.rs2),
        .id_rd           (in_f.rd),
        .id_rs2_used     (in_f.used),
        .id_load         (in_f.load),
        .id_jump         (in_f.jump),
        .ex_branch_taken (in_f.br),
        .pc_stall        (pc_stall_f),
        .ifid_hold       (ifid_hold_f),
        .idex_bubble     (idex_bubble_f),
        .ifid_flush      (ifid_flush_f),
        .fwd_a           (fwd_a_f),
        .fwd_b           (fwd_b_f),
        .stall_cycles    (stall_cycles_f)
    );

    dlx_hazard_ctrl #(.FWD_SEL_W(2), .PERF_W(3), .FWD_EN(1'b0)) u_n (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_valid        (in_n.vld),
        .id_rs1          (in_n.rs1),
        .id_rs2          (in_n.rs2),
        .id_rd           (in_n.rd),
        .id_rs2_used     (in_n.used),
        .id_load         (in_n.load),
        .id_jump         (in_n.jump),
        .ex_branch_taken (in_n.br),
        .pc_stall        (pc_stall_n),
        .ifid_hold       (ifid_hold_n),
        .idex_bubble     (idex_bubble_n),
        .ifid_flush      (ifid_flush_n),
        .fwd_a           (fwd_a_n),
        .fwd_b           (fwd_b_n),
        .stall_cycles    (stall_cycles_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic id_t mk(input logic v, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] d, input logic u, input logic l, input logic j);
        id_t r;
        r.vld  = v;
        r.rs1  = a;
        r.rs2  = b;
        r.rd   = d;
        r.used = u;
        r.load = l;
        r.jump = j;
        r.br   = 1'b0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_f(input string tag, input id_t v, input logic [7:0] exp);
        in_f = v;
        #1;
        chk(tag, 32'(ctl_f), 32'(exp));
        tick();
    endtask

    task automatic cyc_n(input string tag, input id_t v, input logic [7:0] exp);
        in_n = v;
        #1;
        chk(tag, 32'(ctl_n), 32'(exp));
        tick();
    endtask

    localparam logic [7:0] STALL = 8'b1110_0000;
    localparam logic [7:0] JFLSH = 8'b0001_0000;
    localparam logic [7:0] BFLSH = 8'b0011_0000;

    initial begin
        id_t nop;
        id_t v;
        total   = 0;
        bad     = 0;
        nop     = '0;
        reset_n = 1'b0;
        in_f    = nop;
        in_n    = nop;
        #3;
        chk("rst_ctl_f", 32'(ctl_f), 32'd0);
        chk("rst_ctl_n", 32'(ctl_n), 32'd0);
        chk("rst_cnt_f", stall_cycles_f, 32'd0);
        #9 reset_n = 1'b1;
        tick();

        // Forwarding build: LW r3 ; ADD r4,r3,r5
        cyc_f("f_lw",          mk(1'b1, 5'd1, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0), 8'h00);
        cyc_f("f_loaduse",     mk(1'b1, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0), STALL);
        cyc_f("f_loaduse_one", mk(1'b1, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0), 8'h00);
        cyc_f("f_fwd_memwb",   nop, 8'b0000_1000);
        chk("f_cnt1", stall_cycles_f, 32'd1);
        // ADD r3 ; SUB r6,r3,r3
        cyc_f("f_add_r3",      mk(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0), 8'h00);
        cyc_f("f_sub_nostall", mk(1'b1, 5'd3, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0), 8'h00);
        cyc_f("f_fwd_exmem",   nop, 8'b0000_0101);
        // ADDI r0 ; ADD r1,r0,r0
        cyc_f("f_addi_r0",     mk(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0), 8'h00);
        cyc_f("f_r0_nostall",  mk(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0), 8'h00);
        cyc_f("f_r0_nofwd",    nop, 8'h00);
        // JAL with no hazard
        cyc_f("f_jal_flush",   mk(1'b1, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0, 1'b1), JFLSH);
        cyc_f("f_jal_once",    nop, 8'h00);
        chk("f_cnt_end", stall_cycles_f, 32'd1);

        // Non-forwarding build: ADD r3 ; ADD r4,r3,r0 -> three stall cycles
        cyc_n("n_add_r3",      mk(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0), 8'h00);
        cyc_n("n_stall_ex",    mk(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0), STALL);
        cyc_n("n_hold_1",      mk(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0), STALL);
        cyc_n("n_hold_2",      mk(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0), STALL);
        chk("n_cnt3", 32'(stall_cycles_n), 32'd3);
        cyc_n("n_release",     mk(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0), 8'h00);
        cyc_n("n_fwd_off",     nop, 8'h00);
        // ADDI r0 ; ADD r1,r0,r0
        cyc_n("n_addi_r0",     mk(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0), 8'h00);
        cyc_n("n_r0_nostall",  mk(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0), 8'h00);
        cyc_n("n_idle",        nop, 8'h00);
        // Branch taken during the second stall cycle
        cyc_n("n_add_r7",      mk(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0), 8'h00);
        cyc_n("n_stall_b",     mk(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0), STALL);
        v    = mk(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        v.br = 1'b1;
        cyc_n("n_br_flush",    v, BFLSH);
        chk("n_cnt_br", 32'(stall_cycles_n), 32'd4);
        cyc_n("n_br_run",      nop, 8'h00);
        // Fill the 3-bit counter to all-ones, then stall again
        cyc_n("n_add_r9",      mk(1'b1, 5'd5, 5'd6, 5'd9, 1'b1, 1'b0, 1'b0), 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc_n("n_fill_stall", mk(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0), STALL);
        end
        chk("n_cnt7", 32'(stall_cycles_n), 32'd7);
        cyc_n("n_fill_rel",    mk(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0), 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc_n("n_sat_stall", mk(1'b1, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0), STALL);
        end
        chk("n_cnt_sat", 32'(stall_cycles_n), 32'd7);
        cyc_n("n_sat_rel",     mk(1'b1, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0), 8'h00);
        // Writer in MEM -> two-cycle wait
        cyc_n("n_gap",         nop, 8'h00);
        cyc_n("n_mem_stall",   mk(1'b1, 5'd11, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0), STALL);
        cyc_n("n_mem_hold",    mk(1'b1, 5'd11, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0), STALL);
        cyc_n("n_mem_rel",     mk(1'b1, 5'd11, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0), 8'h00);
        // Reset asserted mid-HOLD
        cyc_n("n_pre_rst",     mk(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0), STALL);
        in_n = mk(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        #1;
        chk("n_in_hold", 32'(ctl_n), 32'(STALL));
        #2 reset_n = 1'b0;
        #1;
        chk("n_rst_ctl", 32'(ctl_n), 32'd0);
        chk("n_rst_cnt", 32'(stall_cycles_n), 32'd0);
        chk("f_rst_cnt", stall_cycles_f, 32'd0);
        #2 reset_n = 1'b1;
        tick();
        cyc_n("n_post_rst",    mk(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0), 8'h00);
        // Writer in WB -> single stall cycle (no regfile bypass)
        cyc_n("n_gap2",        nop, 8'h00);
        cyc_n("n_gap3",        nop, 8'h00);
        cyc_n("n_wb_stall",    mk(1'b1, 5'd13, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0), STALL);
        cyc_n("n_wb_rel",      mk(1'b1, 5'd13, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0), 8'h00);
        chk("n_cnt_wb", 32'(stall_cycles_n), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dlx_hazard_ctrl.md
# dlx_hazard_ctrl

Pipeline controller for the 5-stage DLX core (IF, ID, EX, MEM, WB). Consumes register fields and control flags from the ID-stage decoder, keeps a shadow copy of in-flight destination registers, and issues stall, bubble, flush and forwarding-select commands to the pipeline registers and EX operand muxes. It is the single authority for hazard sequencing; no other block stalls the pipeline.

## Interface
- `FWD_SEL_W`, 2: width of the forwarding selects.
- `PERF_W`, 32: width of the stall-cycle counter.
- `clk` in 1: core clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: decoder register fields.
- `id_rs2_used` in 1: instruction reads `id_rs2`. R-type, store and branch set it; ALU-immediate and load clear it.
- `id_load` in 1: decoder `d_load_enable`.
- `id_jump` in 1: decoder `Pc_cmd_ID` (J, JAL, JR, JALR).
- `ex_branch_taken` in 1: BEQZ/BNEZ resolved taken in EX.
- `pc_stall` out 1: hold PC.
- `ifid_hold` out 1: hold the IF/ID register.
- `idex_bubble` out 1: load a NOP into ID/EX.
- `ifid_flush` out 1: load a NOP into IF/ID.
- `fwd_a`, `fwd_b` out `FWD_SEL_W`: EX operand A/B source. 0 = regfile, 1 = EX/MEM result, 2 = MEM/WB result.
- `stall_cycles` out `PERF_W`: saturating count of stalled cycles.

## Operation
- Shadow pipeline registers, each clocked on `clk`:
  - EX stage: `{vld, rd, load, rs1, rs2, rs2_used}`.
  - MEM stage: `{vld, rd, load}`.
  - WB stage: `{vld, rd}`.
- Normal advance: ID fields enter EX, EX moves to MEM, MEM moves to WB.
- Writer rule: an entry with `rd == 0` is never a hazard source and is never a forwarding source.
- Hazard test: an ID source (rs1 always, rs2 only if `rs2_used`) matches a valid non-zero stage `rd`.
- FSM has two states, RUN and HOLD.
  - RUN: if `id_valid` and a hazard exists per the Configuration rule, assert `pc_stall`, `ifid_hold` and `idex_bubble` in the same cycle. Go to HOLD with `hold_cnt` set to the remaining wait minus 1. A wait of 1 returns directly to RUN.
  - HOLD: keep all three stall outputs high and decrement `hold_cnt`. At 0, go to RUN, with the hazard re-evaluated combinationally.
- Flush priority:
  - `ex_branch_taken`: assert `ifid_flush` and `idex_bubble`, deassert `pc_stall`/`ifid_hold`, and force the FSM to RUN (this kills the stalled instruction).
  - `id_jump` in RUN with no hazard: assert `ifid_flush` only.
  - A jump that is itself stalled does not flush until its stall ends.
  - A branch flush overrides a jump flush.
- Bubble: the EX shadow `vld` is loaded with 0. A bubble never matches any source.
- Forwarding (EX-stage sources vs MEM/WB shadows): the EX/MEM match wins over the MEM/WB match; otherwise select 0.
- `stall_cycles` increments on every cycle with `pc_stall` high and saturates at all-ones.

## Timing
- `pc_stall`, `ifid_hold`, `idex_bubble`, `ifid_flush`, `fwd_a`, `fwd_b`: combinational from inputs and registered state, valid in the same cycle.
- Shadows, FSM, `hold_cnt` and `stall_cycles` update on the rising edge of `clk`.
- Reset (asserted at any time, including mid-HOLD):
  - All shadow `vld` = 0, FSM = RUN, `hold_cnt` = 0, `stall_cycles` = 0.
  - Outputs read as 0, because the shadows are invalid; this also holds while `id_valid` = 0.
- Simultaneous hazard and `ex_branch_taken`: the flush wins; the stall count does not increment that cycle.

## Configuration
- Macro `DLX_FORWARDING_EN`.
- Defined:
  - Forwarding is active.
  - Only a load in EX matching an ID source causes a stall, of 1 cycle.
- Undefined:
  - `fwd_a`/`fwd_b` are tied to 0.
  - Any match stalls until the writer leaves WB. The wait is 3 cycles if the writer is in EX, 2 if in MEM, and 1 if in WB (the regfile does not bypass write to read).
  - When several stages match, the youngest match sets the wait.

## Structure
- Package `dlx_pkg` holds:
  - `fwd_sel_e` enum: `FWD_RF`, `FWD_EXMEM`, `FWD_MEMWB`.
  - `hz_state_e` enum: `HZ_RUN`, `HZ_HOLD`.
  - Struct `shadow_ex_t`.
  - Constant `REG_ZERO = 5'd0`.
- One sub-module, `dlx_fwd_unit`: combinational forwarding compare for one operand, instantiated twice.

## Test plan
- Forwarding on:
  - `LW r3` then `ADD r4,r3,r5` -> exactly 1 cycle of `pc_stall`/`idex_bubble`, then `fwd_a` = 2 on the ADD in EX; `stall_cycles` = 1.
  - `ADD r3` then `SUB r6,r3,r3` -> no stall, `fwd_a` = `fwd_b` = 1.
- Forwarding off: `ADD r3` then `ADD r4,r3,r0` -> 3 stall cycles, then `fwd_a` = 0.
- `ADDI r0,...` then `ADD r1,r0,r0` -> no stall and no forward in either configuration.
- Stall in progress (forwarding off, cycle 2) with `ex_branch_taken` = 1:
  - Same cycle: `ifid_flush` = 1, `idex_bubble` = 1, `pc_stall` = 0.
  - Next cycle: FSM in RUN.
- Other cases:
  - JAL with no hazard -> `ifid_flush` for 1 cycle.
  - `reset_n` low mid-HOLD -> all outputs 0 and counter 0 asynchronously.
  - Force `stall_cycles` to all-ones and stall again -> value unchanged.
